// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FSM states, FP alu_control codes and one-hot opcode map for the FPU scheduler
package fpu_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [4:0] FADD  = 5'b10000;
    localparam logic [4:0] FSUB  = 5'b10001;
    localparam logic [4:0] FMUL  = 5'b10010;
    localparam logic [4:0] FDIV  = 5'b10011;
    localparam logic [4:0] FCMP  = 5'b11011;
    localparam logic [4:0] FMIN  = 5'b10110;
    localparam logic [4:0] FMAX  = 5'b10111;
    localparam logic [4:0] FSQRT = 5'b10101;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h04;
    localparam logic [7:0] OP_DIV  = 8'h08;
    localparam logic [7:0] OP_CMP  = 8'h10;
    localparam logic [7:0] OP_MIN  = 8'h20;
    localparam logic [7:0] OP_MAX  = 8'h40;
    localparam logic [7:0] OP_SQRT = 8'h80;

    function automatic logic [7:0] ctrl_to_onehot(input logic [4:0] ctrl);
        case (ctrl)
            FADD:    return OP_ADD;
            FSUB:    return OP_SUB;
            FMUL:    return OP_MUL;
            FDIV:    return OP_DIV;
            FCMP:    return OP_CMP;
            FMIN:    return OP_MIN;
            FMAX:    return OP_MAX;
            FSQRT:   return OP_SQRT;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// fpu_rr_arb2: two-way round-robin grant; a tie goes to the requester not served last
module fpu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic rr_last;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            rr_last <= 1'b1;
        else if (en)
            rr_last <= grant[1];

    always_comb
        grant = &req ? (rr_last ? 2'b01 : 2'b10) : req;

endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: shares one fpu_top between two requesters: arbitrate, pulse opcode, wait with timeout, hold result
module fpu_sched
    import fpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [4:0]  req_ctrl0,
    input  logic [4:0]  req_ctrl1,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        resp_ovf,
    output logic        resp_unf,
    output logic [7:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_out_valid
);

    state_t           state, state_nx;
    logic [1:0]       grant;
    logic             accept, owner, timeout, err_q, ovf_q, unf_q;
    logic [7:0]       op_q, sel_op;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] cnt;

    fpu_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (accept),
        .grant (grant)
    );

    // req_ready is gated by rst so nothing looks grantable while reset is held
    always_comb begin
        req_ready  = (state == IDLE && !rst) ? grant : 2'b00;
        accept     = |(req_valid & req_ready);
        sel_op     = ctrl_to_onehot(req_ready[1] ? req_ctrl1 : req_ctrl0);
        timeout    = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        fpu_opcode = state == ISSUE ? op_q : 8'h00;
        resp_valid = state == HOLD ? {owner, ~owner} : 2'b00;
        resp_data  = data_q;
        resp_err   = err_q;
        resp_ovf   = ovf_q;
        resp_unf   = unf_q;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? (sel_op != 8'h00 ? ISSUE : HOLD) : IDLE;
            ISSUE: state_nx = WAIT;
            WAIT:  state_nx = (fpu_out_valid || timeout) ? HOLD : WAIT;
            HOLD:  state_nx = resp_ready[owner] ? IDLE : HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            owner  <= 1'b0;
            op_q   <= 8'h00;
            fpu_x1 <= 32'h0;
            fpu_x2 <= 32'h0;
            cnt    <= '0;
            data_q <= 32'h0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            state <= state_nx;
            // an illegal opcode goes straight to HOLD with the error already staged
            if (accept) begin
                owner  <= req_ready[1];
                op_q   <= sel_op;
                fpu_x1 <= req_ready[1] ? req_a1 : req_a0;
                fpu_x2 <= req_ready[1] ? req_b1 : req_b0;
                data_q <= 32'h0;
                err_q  <= sel_op == 8'h00;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (state == WAIT && fpu_out_valid) begin
                data_q <= fpu_y;
                err_q  <= 1'b0;
                ovf_q  <= fpu_ovf;
                unf_q  <= fpu_unf;
            end else if (state == WAIT && timeout) begin
                data_q <= 32'h0;
                err_q  <= 1'b1;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end
        end

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: directed scoreboard bench for fpu_sched with an inline fpu_top latency model
module tb_fpu_sched;

    localparam int TO = 64;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] d;
        logic        e, o, u;
    } exp_t;

    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [4:0]  req_ctrl0, req_ctrl1;
    logic [31:0] req_a0, req_b0, req_a1, req_b1, resp_data, fpu_x1, fpu_x2, fpu_y;
    logic        resp_err, resp_ovf, resp_unf, fpu_ovf, fpu_unf, fpu_out_valid;
    logic [7:0]  fpu_opcode;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    fpu_sched #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ctrl0     (req_ctrl0),
        .req_ctrl1     (req_ctrl1),
        .req_a0        (req_a0),
        .req_b0        (req_b0),
        .req_a1        (req_a1),
        .req_b1        (req_b1),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .resp_ovf      (resp_ovf),
        .resp_unf      (resp_unf),
        .fpu_opcode    (fpu_opcode),
        .fpu_x1        (fpu_x1),
        .fpu_x2        (fpu_x2),
        .fpu_y         (fpu_y),
        .fpu_ovf       (fpu_ovf),
        .fpu_unf       (fpu_unf),
        .fpu_out_valid (fpu_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_data"}, resp_data, 32'h0);
        chk({tag, "_flags"}, 32'({resp_err, resp_ovf, resp_unf}), 32'h0);
        chk({tag, "_opcode"}, 32'(fpu_opcode), 32'h0);
        chk({tag, "_x1"}, fpu_x1, 32'h0);
        chk({tag, "_x2"}, fpu_x2, 32'h0);
    endtask

    // lat=0 models an fpu that never answers; oh=0 marks an illegal ctrl
    task automatic run_op(input logic [1:0] vld, input int g, input logic [4:0] ctrl,
                          input logic [31:0] a, input logic [31:0] b, input logic [7:0] oh,
                          input int lat, input logic [31:0] y, input logic o, input logic u,
                          input int bp, input bit keep);
        exp_t       e;
        logic [1:0] gm;
        bit         ok;
        int         n;
        gm = 2'(1 << g);
        ok = oh != 8'h00 && lat != 0;
        if (g == 0) begin
            req_ctrl0 = ctrl; req_a0 = a; req_b0 = b;
        end else begin
            req_ctrl1 = ctrl; req_a1 = a; req_b1 = b;
        end
        req_valid = vld;
        #1;
        chk("grant", 32'(req_ready), 32'(gm));
        e.rv = gm; e.d = ok ? y : 32'h0; e.e = !ok; e.o = ok & o; e.u = ok & u;
        sb.push_back(e);
        cyc();
        if (!keep) req_valid = 2'b00;
        chk("opcode_pulse", 32'(fpu_opcode), 32'(oh));
        chk("busy_req_ready", 32'(req_ready), 32'h0);
        if (oh != 8'h00) begin
            chk("issue_no_resp", 32'(resp_valid), 32'h0);
            chk("issue_x1", fpu_x1, a);
            chk("issue_x2", fpu_x2, b);
            n = lat == 0 ? TO : lat;
            for (int k = 1; k <= n; k++) begin
                cyc();
                chk("wait_opcode", 32'(fpu_opcode), 32'h0);
                chk("wait_no_resp", 32'(resp_valid), 32'h0);
                chk("wait_x1", fpu_x1, a);
                chk("wait_x2", fpu_x2, b);
                chk("wait_req_ready", 32'(req_ready), 32'h0);
                if (lat != 0 && k == lat) begin
                    fpu_out_valid = 1'b1; fpu_y = y; fpu_ovf = o; fpu_unf = u;
                end
            end
            cyc();
            fpu_out_valid = 1'b0; fpu_y = 32'hDEAD_BEEF; fpu_ovf = 1'b0; fpu_unf = 1'b0;
        end
        e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(e.rv));
        chk("resp_data", resp_data, e.d);
        chk("resp_flags", 32'({resp_err, resp_ovf, resp_unf}), 32'({e.e, e.o, e.u}));
        chk("hold_req_ready", 32'(req_ready), 32'h0);
        for (int k = 0; k < bp; k++) begin
            resp_ready = ~gm;
            fpu_out_valid = k == 2; fpu_y = 32'h1234_5678; fpu_ovf = 1'b1; fpu_unf = 1'b1;
            cyc();
            chk("bp_valid", 32'(resp_valid), 32'(e.rv));
            chk("bp_data", resp_data, e.d);
            chk("bp_flags", 32'({resp_err, resp_ovf, resp_unf}), 32'({e.e, e.o, e.u}));
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        fpu_out_valid = 1'b0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
        resp_ready = gm;
        #1;
        chk("consume_req_ready", 32'(req_ready), 32'h0);
        cyc();
        resp_ready = 2'b00;
        chk("released", 32'(resp_valid), 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b11; resp_ready = 2'b00;
        req_ctrl0 = 5'b10000; req_ctrl1 = 5'b10000;
        req_a0 = 32'h0; req_b0 = 32'h0; req_a1 = 32'h0; req_b1 = 32'h0;
        fpu_y = 32'h0; fpu_ovf = 1'b0; fpu_unf = 1'b0; fpu_out_valid = 1'b0;
        #3;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        cyc();

        // single op on each port
        run_op(2'b01, 0, 5'b10000, 32'h3F80_0000, 32'h4000_0000, 8'h01, 3, 32'h4040_0000, 1'b0, 1'b0, 0, 1'b0);
        run_op(2'b10, 1, 5'b10010, 32'h7F00_0000, 32'h4100_0000, 8'h04, 1, 32'h7F80_0000, 1'b1, 1'b0, 0, 1'b0);

        // contention with both valid held
        run_op(2'b11, 0, 5'b10001, 32'h4000_0000, 32'h3F80_0000, 8'h02, 2, 32'h3F80_0000, 1'b0, 1'b0, 0, 1'b1);
        run_op(2'b11, 1, 5'b10011, 32'h0080_0000, 32'h4B00_0000, 8'h08, 5, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b1);
        run_op(2'b11, 0, 5'b11011, 32'h4040_0000, 32'h4040_0000, 8'h10, 1, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b1);
        run_op(2'b11, 1, 5'b10110, 32'hC000_0000, 32'h4000_0000, 8'h20, 4, 32'hC000_0000, 1'b0, 1'b0, 0, 1'b1);

        // backpressure with req1 pending, then req1 served
        run_op(2'b11, 0, 5'b10111, 32'h4120_0000, 32'h4140_0000, 8'h40, 2, 32'h4140_0000, 1'b1, 1'b1, 10, 1'b1);
        run_op(2'b10, 1, 5'b10101, 32'h4080_0000, 32'h0, 8'h80, 3, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0);

        // illegal ctrl, timeout, out_valid on the final WAIT cycle
        run_op(2'b01, 0, 5'b10100, 32'h1111_1111, 32'h2222_2222, 8'h00, 3, 32'h5555_5555, 1'b1, 1'b1, 0, 1'b0);
        run_op(2'b01, 0, 5'b10000, 32'h3F80_0000, 32'h3F80_0000, 8'h01, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        run_op(2'b01, 0, 5'b10000, 32'h3F80_0000, 32'h3F80_0000, 8'h01, TO, 32'h4000_0000, 1'b0, 1'b0, 0, 1'b0);

        // spurious out_valid while idle
        fpu_out_valid = 1'b1; fpu_y = 32'hABCD_0123;
        cyc();
        fpu_out_valid = 1'b0;
        chk("spurious_idle", 32'(resp_valid), 32'h0);
        cyc();
        chk("spurious_idle2", 32'(resp_valid), 32'h0);

        // reset mid-WAIT
        req_ctrl0 = 5'b10010; req_a0 = 32'h4000_0000; req_b0 = 32'h4000_0000; req_valid = 2'b01;
        #1;
        chk("pre_reset_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        #2;
        rst = 1'b1; req_valid = 2'b11;
        #1;
        chk_zero_outputs("midwait_reset");
        @(negedge clk);
        rst = 1'b0; req_valid = 2'b00;
        cyc();
        fpu_out_valid = 1'b1; fpu_y = 32'h4080_0000;
        cyc();
        fpu_out_valid = 1'b0;
        chk("late_out_valid", 32'(resp_valid), 32'h0);
        cyc();
        chk("late_out_valid2", 32'(resp_valid), 32'h0);
        run_op(2'b11, 0, 5'b10000, 32'h4000_0000, 32'h4000_0000, 8'h01, 2, 32'h4080_0000, 1'b0, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
